// File: rtl/piso_serial_tx_if.sv
// ---------------------------------------------------------------------------
// piso_serial_tx_if
// Bundles the producer handshake and the serial-side outputs of
// piso_serial_tx.
//   load_data   : parallel word offered by the producer (WIDTH bits)
//   load_valid  : producer offers load_data
//   load_ready  : transmitter accepts a word this cycle
//   sdo         : serial data bit
//   sdo_valid   : sdo carries a frame bit this cycle
//   frame_start : first bit of a frame
//   done        : last bit of a frame
//   busy        : a frame is being shifted (same as sdo_valid)
// Modports: master = producer/observer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface piso_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             sdo;
  logic             sdo_valid;
  logic             frame_start;
  logic             done;
  logic             busy;

  modport master (
    output load_data, load_valid,
    input  load_ready, sdo, sdo_valid, frame_start, done, busy
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, sdo, sdo_valid, frame_start, done, busy
  );
endinterface

// File: rtl/piso_serial_tx.sv
// ---------------------------------------------------------------------------
// piso_serial_tx
// Parallel-in serial-out transmitter. Takes one WIDTH-bit word per
// load_valid/load_ready handshake and sends it one bit per clk cycle,
// flagging the first bit with frame_start and the last with done.
//
// Parameters:
//   WIDTH     : word width, 2..32
//   LSB_FIRST : 1 = bit 0 goes first, 0 = bit WIDTH-1 goes first
// Ports:
//   clk         : clock, rising edge
//   async_reset : asynchronous active-high reset
//   bus         : piso_serial_tx_if slave modport (handshake + serial out)
// Build option:
//   PISO_PARITY_EN : append one even-parity bit (XOR of the word) after the
//                    data bits; done and the load_ready window move to it.
// ---------------------------------------------------------------------------
module piso_serial_tx #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              async_reset,
  piso_serial_tx_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef PISO_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;   // index of the data bit now on sdo
  logic              sdo_q, sdo_d;
  logic              sdo_valid_q, sdo_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              done_q, done_d;
`ifdef PISO_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic last_bit;
  logic load_ready;
  logic accept;

  // Final bit cycle of the frame: the only cycle (besides IDLE) in which a
  // new word may be taken, so back-to-back frames have no gap.
`ifdef PISO_PARITY_EN
  assign last_bit = (state_q == ST_PARITY);
`else
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
`endif

  assign load_ready = (state_q == ST_IDLE) || last_bit;
  assign accept     = bus.load_valid && load_ready;

  // The first bit is placed on sdo at load, so the register keeps the word
  // pre-shifted by one and the head of the register is always the next bit.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    sdo_d         = 1'b0;
    sdo_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d      = parity_q;
`endif

    if (accept) begin
      shreg_d       = shift_one(bus.load_data);
      cnt_d         = '0;
      sdo_d         = head_bit(bus.load_data);
      sdo_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      state_d       = ST_SHIFT;
`ifdef PISO_PARITY_EN
      parity_d      = ^bus.load_data;
`endif
    end else begin
      unique case (state_q)
        ST_SHIFT: begin
          if (cnt_q != LAST_IDX) begin
            sdo_d       = head_bit(shreg_q);
            shreg_d     = shift_one(shreg_q);
            cnt_d       = cnt_q + CNT_W'(1);
            sdo_valid_d = 1'b1;
`ifndef PISO_PARITY_EN
            done_d      = (cnt_q == PENULT_IDX);
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_d     = ST_PARITY;
            sdo_d       = parity_q;
            sdo_valid_d = 1'b1;
            done_d      = 1'b1;
`else
            state_d     = ST_IDLE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: state_d = ST_IDLE;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      sdo_q         <= 1'b0;
      sdo_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      sdo_q         <= sdo_d;
      sdo_valid_q   <= sdo_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
`ifdef PISO_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.sdo         = sdo_q;
  assign bus.sdo_valid   = sdo_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.done        = done_q;
  assign bus.busy        = sdo_valid_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_serial_tx
// Self-checking bench for piso_serial_tx, WIDTH=8. Two instances share the
// clock and reset: u_lsb (LSB_FIRST=1) and u_msb (LSB_FIRST=0).
// Expected serial sequences are written as 8-bit constants whose bit 7 is
// the first bit on the wire. Define PISO_PARITY_EN for the parity build.
// ---------------------------------------------------------------------------
module tb_piso_serial_tx;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic async_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  piso_serial_tx_if #(.WIDTH(8)) if_lsb ();
  piso_serial_tx_if #(.WIDTH(8)) if_msb ();

  piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .async_reset(async_reset), .bus(if_lsb)
  );
  piso_serial_tx #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk(clk), .async_reset(async_reset), .bus(if_msb)
  );

  typedef struct {
    int         which;    // 0 = u_lsb, 1 = u_msb
    logic [7:0] data;
    logic [7:0] seq;      // bit 7 = first bit transmitted
    logic       par;      // expected parity bit
    string      name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [7:0] d);
    if (which == 0) begin
      if_lsb.load_valid = v;
      if_lsb.load_data  = d;
    end else begin
      if_msb.load_valid = v;
      if_msb.load_data  = d;
    end
  endtask

  // o = {sdo, sdo_valid, frame_start, done, busy, load_ready}
  task automatic sample(input int which, output logic [5:0] o);
    if (which == 0)
      o = {if_lsb.sdo, if_lsb.sdo_valid, if_lsb.frame_start, if_lsb.done,
           if_lsb.busy, if_lsb.load_ready};
    else
      o = {if_msb.sdo, if_msb.sdo_valid, if_msb.frame_start, if_msb.done,
           if_msb.busy, if_msb.load_ready};
  endtask

  task automatic idle_check(input int which, input string name);
    logic [5:0] o;
    @(negedge clk);
    sample(which, o);
    check({name, ".idle_sdo"},   32'(o[5]), 32'd0);
    check({name, ".idle_valid"}, 32'(o[4]), 32'd0);
    check({name, ".idle_fs"},    32'(o[3]), 32'd0);
    check({name, ".idle_done"},  32'(o[2]), 32'd0);
    check({name, ".idle_busy"},  32'(o[1]), 32'd0);
    check({name, ".idle_ready"}, 32'(o[0]), 32'd1);
  endtask

  task automatic start(input int which, input logic [7:0] d);
    @(negedge clk);
    drive(which, 1'b1, d);
  endtask

  // Checks one frame whose accept edge has just happened. A word offered
  // while load_ready=0 (cycles 3..4) must be ignored. With chain set, the
  // next word is offered during the final bit.
  task automatic frame(input int which, input logic [7:0] seq,
                       input logic par, input bit chain,
                       input logic [7:0] chain_data, input string name);
    logic [5:0] o;
    logic       exp_bit;
    bit         last;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 0) drive(which, 1'b0, 8'h00);
      if (i == 2) drive(which, 1'b1, 8'h3C);
      if (i == 3) drive(which, 1'b0, 8'h00);
      sample(which, o);
      exp_bit = (i < 8) ? seq[7-i] : par;
      last    = (i == FRAME - 1);
      check($sformatf("%s[%0d].sdo", name, i),   32'(o[5]), 32'(exp_bit));
      check($sformatf("%s[%0d].valid", name, i), 32'(o[4]), 32'd1);
      check($sformatf("%s[%0d].fs", name, i),    32'(o[3]), 32'(i == 0));
      check($sformatf("%s[%0d].done", name, i),  32'(o[2]), 32'(last));
      check($sformatf("%s[%0d].busy", name, i),  32'(o[1]), 32'd1);
      check($sformatf("%s[%0d].ready", name, i), 32'(o[0]), 32'(last));
      if (last && chain) drive(which, 1'b1, chain_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[8];
    logic [5:0] o;

    vecs[0] = '{0, 8'hA5, 8'hA5, 1'b0, "lsb_a5"};
    vecs[1] = '{1, 8'hA5, 8'hA5, 1'b0, "msb_a5"};
    vecs[2] = '{1, 8'h01, 8'h01, 1'b1, "msb_01"};
    vecs[3] = '{0, 8'h01, 8'h80, 1'b1, "lsb_01"};
    vecs[4] = '{0, 8'h07, 8'hE0, 1'b1, "lsb_07"};
    vecs[5] = '{0, 8'h03, 8'hC0, 1'b0, "lsb_03"};
    vecs[6] = '{1, 8'h0F, 8'h0F, 1'b0, "msb_0f"};
    vecs[7] = '{0, 8'hF0, 8'h0F, 1'b0, "lsb_f0"};

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // Reset: outputs must be clear immediately, before any clock edge.
    async_reset = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      sample(w, o);
      check($sformatf("rst%0d.sdo", w),   32'(o[5]), 32'd0);
      check($sformatf("rst%0d.valid", w), 32'(o[4]), 32'd0);
      check($sformatf("rst%0d.fs", w),    32'(o[3]), 32'd0);
      check($sformatf("rst%0d.done", w),  32'(o[2]), 32'd0);
      check($sformatf("rst%0d.busy", w),  32'(o[1]), 32'd0);
      check($sformatf("rst%0d.ready", w), 32'(o[0]), 32'd1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    async_reset = 1'b0;

    // Table-driven single frames.
    foreach (vecs[k]) begin
      idle_check(vecs[k].which, vecs[k].name);
      start(vecs[k].which, vecs[k].data);
      frame(vecs[k].which, vecs[k].seq, vecs[k].par, 1'b0, 8'h00,
            vecs[k].name);
      idle_check(vecs[k].which, {vecs[k].name, ".after"});
    end

    // Back-to-back: FF then 00 offered in the final bit cycle.
    start(0, 8'hFF);
    frame(0, 8'hFF, 1'b0, 1'b1, 8'h00, "b2b_ff");
    frame(0, 8'h00, 1'b0, 1'b0, 8'h00, "b2b_00");
    idle_check(0, "b2b.after");

    // Reset mid-frame: F0 (LSB first -> 0,0,0,...), reset after 3 bits.
    start(0, 8'hF0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) drive(0, 1'b0, 8'h00);
      sample(0, o);
      check($sformatf("midrst[%0d].sdo", i),   32'(o[5]), 32'd0);
      check($sformatf("midrst[%0d].valid", i), 32'(o[4]), 32'd1);
    end
    #2;
    async_reset = 1'b1;
    #1;
    sample(0, o);
    check("midrst.valid", 32'(o[4]), 32'd0);
    check("midrst.done",  32'(o[2]), 32'd0);
    check("midrst.busy",  32'(o[1]), 32'd0);
    check("midrst.ready", 32'(o[0]), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sample(0, o);
      check($sformatf("midrst_hold[%0d].done", i),  32'(o[2]), 32'd0);
      check($sformatf("midrst_hold[%0d].valid", i), 32'(o[4]), 32'd0);
    end
    async_reset = 1'b0;
    idle_check(0, "postrst");
    start(0, 8'h0F);
    frame(0, 8'hF0, 1'b0, 1'b0, 8'h00, "postrst_0f");
    idle_check(0, "postrst.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in serial-out transmitter, built from D flip-flops. Accepts one WIDTH-bit word per handshake and drives it out one bit per clk cycle, with a valid and a frame-start marker. It is the transmit end of the bit-serial link; a SIPO receiver on the far side rebuilds words from sdo/sdo_valid/frame_start. It sits between a register-level producer and the serial wire.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.
LSB_FIRST, 1, 1 = bit 0 is transmitted first; 0 = bit WIDTH-1 is transmitted first.

Ports:
clk  input  1  single clock; all state changes on rising edge.
async_reset  input  1  asynchronous, active-high reset. Assertion takes effect immediately; release is synchronous to clk by the system.
load_data  input  WIDTH  parallel word to transmit.
load_valid  input  1  producer offers load_data.
load_ready  output  1  transmitter can accept a word this cycle.
sdo  output  1  serial data bit.
sdo_valid  output  1  sdo carries a frame bit this cycle.
frame_start  output  1  high on the first bit of each frame.
done  output  1  one-cycle pulse on the last bit of each frame.
busy  output  1  high while a frame is being shifted.

Behaviour:
- Reset (async_reset=1): state=IDLE; shift register, bit counter, sdo, sdo_valid, frame_start, done and busy all 0. load_ready=1, because it decodes IDLE. Reset mid-frame aborts the frame at once; the remaining bits are never sent and there is no done pulse.
- States:
  - IDLE: outputs sdo_valid=0, sdo=0, busy=0.
  - SHIFT: one data bit per cycle.
  - PARITY: only with the optional feature.
- Accept: a word is taken on a rising edge where load_valid && load_ready. The shift register loads load_data, the counter is set to 0, and the state goes to SHIFT.
- Latency:
  - Accept at edge k puts the first bit on sdo in the cycle after edge k, with sdo_valid=1 and frame_start=1.
  - The following bits go out one per cycle, WIDTH cycles in total.
  - All serial outputs are registered.
- Bit order:
  - LSB_FIRST=1 sends load_data[0] first, then [1], and so on up to [WIDTH-1].
  - LSB_FIRST=0 sends [WIDTH-1] first, down to [0].
- frame_start is high only in the first bit cycle.
- done is high only in the final bit cycle of the frame: data bit WIDTH-1, or the parity bit when parity is enabled.
- busy equals sdo_valid.
- load_ready:
  - 1 in IDLE.
  - 1 in the final bit cycle of a frame.
  - 0 otherwise.
  - It is combinational from state and counter, and never depends on load_valid.
- Back-to-back: a word accepted in the final bit cycle starts the next frame in the very next cycle. There is no idle gap: sdo_valid stays 1 and frame_start pulses again.
- A final bit cycle with no accept returns to IDLE. sdo_valid=0 in the next cycle.
- load_data changing while load_ready=0 has no effect.
- load_valid with load_ready=0 is not accepted. The producer holds it.
- Counter width is clog2(WIDTH+1). The counter never wraps past WIDTH-1; the terminal compare is the exact value WIDTH-1.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, a PARITY state sends one extra bit on sdo, with sdo_valid=1.
  - The bit is the even parity of the word, i.e. the XOR of all WIDTH bits, computed at load.
  - The frame is WIDTH+1 cycles long.
  - done and the load_ready window move to the parity cycle.
  - Data bit WIDTH-1 no longer asserts load_ready.
- Undefined: there is no PARITY state and no parity logic, and the frame is exactly WIDTH cycles.

Test Plan:
1. Reset: hold async_reset=1 for 3 cycles, with a pulse asserted mid-cycle between clock edges. Required: sdo=0, sdo_valid=0, frame_start=0, done=0, busy=0 immediately, and load_ready=1.
2. Single frame, WIDTH=8, LSB_FIRST=1: load 8'hA5 in IDLE. Required: starting in the next cycle, sdo=1,0,1,0,0,1,0,1. sdo_valid=1 for exactly 8 cycles, frame_start only in cycle 1, done only in cycle 8, then IDLE.
3. MSB first, LSB_FIRST=0: load 8'hA5. Required: sdo=1,0,1,0,0,1,0,1, which is the same as test 2 because A5 is a palindrome. Then load 8'h01. Required: sdo=0,0,0,0,0,0,0,1, with done on the 1.
4. Back-to-back: load 8'hFF, then hold load_valid=1 with 8'h00 during the final bit. Required: 16 contiguous sdo_valid cycles (eight 1s then eight 0s), frame_start in cycles 1 and 9, done in cycles 8 and 16.
5. Reset mid-frame: load 8'hF0, then assert async_reset after 3 bits. Required: sdo_valid drops to 0 immediately, there is no done pulse, and load_ready=1. After release, loading 8'h0F sends a full clean frame.
6. Parity, PISO_PARITY_EN defined, WIDTH=8: load 8'h07. Required: 9 sdo_valid cycles, the 9th bit=1, done and load_ready only in cycle 9. Then load 8'h03: 9th bit=0.
